instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction word emitted during NOP insertion (addi x0,x0,0).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with these ports:
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 PCSel_i  input  1  redirect request from control (taken branch/jump).
REQ-007 target_pc_i  input  32  redirect target; bits [1:0] ignored, forced 0.
REQ-008 insert_nop_flag_i  input  1  control request to present NOP to decode.
REQ-009 imem_req_o  output  1  instruction-memory request valid.
REQ-010 imem_addr_o  output  32  request word address.
REQ-011 imem_gnt_i  input  1  memory accepts request this cycle.
REQ-012 imem_rvalid_i  input  1  response data valid.
REQ-013 imem_rdata_i  input  32  response instruction word.
REQ-014 instr_valid_o  output  1  instruction available to decode.
REQ-015 instr_o  output  32  instruction to decode.
REQ-016 instr_pc_o  output  32  PC of instr_o.
REQ-017 instr_ready_i  input  1  decode consumes instr_o this cycle.

Function
REQ-018 The block SHALL hold fetch_pc, a 3-state FSM {IDLE, WAIT, DRAIN} and a 2-entry FIFO of {pc, instr}.
REQ-019 IDLE: imem_req_o=1 iff FIFO occupancy < 2; imem_addr_o=fetch_pc; on req&gnt -> WAIT, fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
REQ-020 imem_req_o and imem_addr_o SHALL stay stable while req=1 and gnt=0 unless a redirect occurs.
REQ-021 WAIT: imem_req_o=0; on rvalid push {fetched pc, rdata} to FIFO and -> IDLE; at most one outstanding request ever.
REQ-022 Redirect (PCSel_i=1) SHALL be accepted in any state/cycle: FIFO flushed, fetch_pc <= {target_pc_i[31:2],2'b00} next cycle.
REQ-023 Redirect in IDLE without gnt -> IDLE; with same-cycle req&gnt -> DRAIN.
REQ-024 Redirect in WAIT without rvalid -> DRAIN; with same-cycle rvalid -> response discarded, -> IDLE.
REQ-025 DRAIN: imem_req_o=0; next rvalid discarded (no push) -> IDLE; redirect in DRAIN updates fetch_pc, stays DRAIN.
REQ-026 instr_valid_o = FIFO non-empty or insert_nop_flag_i; instr_o/instr_pc_o = FIFO head when not inserting.
REQ-027 insert_nop_flag_i=1: instr_o=NOP_INSTR, instr_pc_o=head pc (fetch_pc if empty), instr_valid_o=1, FIFO NOT popped regardless of instr_ready_i.
REQ-028 Pop iff instr_valid_o & instr_ready_i & !insert_nop_flag_i & FIFO non-empty; push and pop in same cycle SHALL leave occupancy unchanged.
REQ-029 Redirect has priority over push and pop in the same cycle; outputs during that cycle reflect pre-flush head.
REQ-030 Fetch latency: response in cycle N appears on instr_o in cycle N+1 (registered FIFO).

Reset
REQ-031 While rst=1: fetch_pc=RESET_PC, FSM=IDLE, FIFO empty, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0 (unless insert_nop_flag_i), instr_o=0, instr_pc_o=0.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request; a response arriving after reset release while in IDLE SHALL be ignored.
REQ-033 imem_req_o SHALL assert in the first cycle after rst deasserts.

Verification
REQ-034 Reset release, gnt=1, rvalid one cycle after each gnt, ready=1 -> instr_pc_o sequence 0x0,0x4,0x8 matching rdata.
REQ-035 instr_ready_i=0 for 10 cycles -> exactly 2 entries buffered, imem_req_o=0, no data lost; ready=1 drains in order.
REQ-036 PCSel_i=1, target_pc_i=0x0000_0103 while WAIT -> DRAIN, stale rvalid discarded, next imem_addr_o=0x0000_0100.
REQ-037 insert_nop_flag_i=1 for 2 cycles, FIFO holding pc 0x20 -> instr_o=0x0000_0013 twice, then pc 0x20 instruction delivered.
REQ-038 fetch_pc=0xFFFF_FFFC granted -> next imem_addr_o=0x0000_0000.
REQ-039 rst asserted in WAIT, rvalid 2 cycles after release -> no push, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: control redirect, instruction-memory and decode handshakes of the fetch unit
interface instr_fetch_unit_if;
  logic        PCSel_i;
  logic [31:0] target_pc_i;
  logic        insert_nop_flag_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  modport master (
    input  PCSel_i, target_pc_i, insert_nop_flag_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );
  modport slave (
    output PCSel_i, target_pc_i, insert_nop_flag_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher with a 2-entry {pc, instr} buffer to decode
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;
  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic [31:0] pc_q [2];
  logic [31:0] ins_q [2];
  logic        rd_q, wr_q;
  logic [1:0]  cnt_q;
  logic        empty, fire, push, pop, redir, nop, rvalid;
  always_comb begin
    redir = bus.PCSel_i;
    nop = bus.insert_nop_flag_i;
    rvalid = bus.imem_rvalid_i;
    empty = cnt_q == 2'd0;
    bus.imem_req_o = !rst && state_q == IDLE && cnt_q != 2'd2;
    bus.imem_addr_o = fetch_pc_q;
    fire = bus.imem_req_o && bus.imem_gnt_i;
    push = state_q == WAIT && rvalid && !redir;
    pop = !empty && bus.instr_ready_i && !nop;
    bus.instr_valid_o = !empty || nop;
    bus.instr_o = nop ? NOP_INSTR : empty ? 32'h0 : ins_q[rd_q];
    bus.instr_pc_o = !empty ? pc_q[rd_q] : nop ? fetch_pc_q : 32'h0;
    req_pc_d = fire ? fetch_pc_q : req_pc_q;
    fetch_pc_d = redir ? {bus.target_pc_i[31:2], 2'b00} : fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    // a redirect racing an in-flight request must swallow that request's response
    state_d = state_q == IDLE ? (fire ? (redir ? DRAIN : WAIT) : IDLE)
            : state_q == WAIT ? (rvalid ? IDLE : redir ? DRAIN : WAIT)
            : (rvalid ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q <= RESET_PC;
      cnt_q <= 2'd0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= req_pc_d;
      if (redir) begin
        cnt_q <= 2'd0;
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 2'(push) - 2'(pop);
        if (push) wr_q <= ~wr_q;
        if (pop) rd_q <= ~rd_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_q] <= req_pc_q;
      ins_q[wr_q] <= bus.imem_rdata_i;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed cycle-by-cycle checks of fetch, buffering, redirect, NOP insertion and reset
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  instr_fetch_unit_if bus();
  instr_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic g, input logic v, input logic [31:0] d, input logic r,
                       input logic s, input logic [31:0] t, input logic n);
    @(negedge clk);
    bus.imem_gnt_i = g;
    bus.imem_rvalid_i = v;
    bus.imem_rdata_i = d;
    bus.instr_ready_i = r;
    bus.PCSel_i = s;
    bus.target_pc_i = t;
    bus.insert_nop_flag_i = n;
    #1;
  endtask
  initial begin
    bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.imem_rdata_i = 0; bus.instr_ready_i = 0;
    bus.PCSel_i = 0; bus.target_pc_i = 0; bus.insert_nop_flag_i = 0;
    #2 rst = 1;
    #2;
    chk("rst_req", bus.imem_req_o, 0);
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    chk("rst_valid", bus.instr_valid_o, 0);
    chk("rst_instr", bus.instr_o, 32'h0);
    chk("rst_pc", bus.instr_pc_o, 32'h0);
    bus.insert_nop_flag_i = 1;
    #1;
    chk("rst_nop_valid", bus.instr_valid_o, 1);
    chk("rst_nop_instr", bus.instr_o, 32'h13);
    bus.insert_nop_flag_i = 0;
    @(negedge clk) rst = 0;
    #1;
    chk("rel_req", bus.imem_req_o, 1);
    // in-order stream with ready high
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("a1_addr", bus.imem_addr_o, 32'h0);
    chk("a1_valid", bus.instr_valid_o, 0);
    drive(0, 1, 32'h1111_0000, 1, 0, 0, 0);
    chk("a2_req", bus.imem_req_o, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("a3_instr", bus.instr_o, 32'h1111_0000);
    chk("a3_pc", bus.instr_pc_o, 32'h0);
    chk("a3_addr", bus.imem_addr_o, 32'h4);
    drive(0, 1, 32'h2222_0004, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("a5_instr", bus.instr_o, 32'h2222_0004);
    chk("a5_pc", bus.instr_pc_o, 32'h4);
    chk("a5_addr", bus.imem_addr_o, 32'h8);
    drive(0, 1, 32'h3333_0008, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("a7_instr", bus.instr_o, 32'h3333_0008);
    chk("a7_pc", bus.instr_pc_o, 32'h8);
    chk("a7_req", bus.imem_req_o, 1);
    chk("a7_addr", bus.imem_addr_o, 32'hC);
    // decode stalled: buffer fills to two, then requests stop
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h4444_000C, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("b_full_req", bus.imem_req_o, 0);
      chk("b_full_head", bus.instr_o, 32'h3333_0008);
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("b4_instr", bus.instr_o, 32'h3333_0008);
    chk("b4_req", bus.imem_req_o, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("b5_instr", bus.instr_o, 32'h4444_000C);
    chk("b5_pc", bus.instr_pc_o, 32'hC);
    chk("b5_req", bus.imem_req_o, 1);
    chk("b5_addr", bus.imem_addr_o, 32'h10);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("b6_valid", bus.instr_valid_o, 0);
    chk("b6_addr_stable", bus.imem_addr_o, 32'h10);
    // redirect while waiting: stale response dropped
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 32'h0000_0103, 0);
    chk("c2_req", bus.imem_req_o, 0);
    drive(0, 1, 32'hDEAD_0010, 1, 0, 0, 0);
    chk("c3_req", bus.imem_req_o, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("c4_valid", bus.instr_valid_o, 0);
    chk("c4_addr", bus.imem_addr_o, 32'h100);
    // NOP insertion holds the head
    drive(0, 0, 0, 1, 1, 32'h20, 0);
    chk("d1_addr", bus.imem_addr_o, 32'h100);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("d2_addr", bus.imem_addr_o, 32'h20);
    drive(0, 1, 32'h5555_0020, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0, 0, 1);
      chk("d_nop_instr", bus.instr_o, 32'h13);
      chk("d_nop_pc", bus.instr_pc_o, 32'h20);
      chk("d_nop_valid", bus.instr_valid_o, 1);
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("d6_instr", bus.instr_o, 32'h5555_0020);
    chk("d6_pc", bus.instr_pc_o, 32'h20);
    drive(0, 0, 0, 1, 0, 0, 1);
    chk("d7_nop_empty_pc", bus.instr_pc_o, 32'h24);
    chk("d7_nop_empty_valid", bus.instr_valid_o, 1);
    // address wrap
    drive(0, 0, 0, 1, 1, 32'hFFFF_FFFF, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("e2_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    drive(0, 1, 32'h6666_FFFC, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("e4_instr", bus.instr_o, 32'h6666_FFFC);
    chk("e4_pc", bus.instr_pc_o, 32'hFFFF_FFFC);
    chk("e4_addr_wrap", bus.imem_addr_o, 32'h0);
    // redirect with simultaneous response: flush wins, outputs show pre-flush head
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h7777_0000, 0, 1, 32'h40, 0);
    chk("f2_head", bus.instr_o, 32'h6666_FFFC);
    chk("f2_valid", bus.instr_valid_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("f3_valid", bus.instr_valid_o, 0);
    chk("f3_addr", bus.imem_addr_o, 32'h40);
    // reset with a request outstanding
    drive(1, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    bus.imem_gnt_i = 0;
    #1;
    chk("g_rst_req", bus.imem_req_o, 0);
    chk("g_rst_addr", bus.imem_addr_o, 32'h0);
    @(negedge clk) rst = 0;
    #1;
    chk("g_rel_req", bus.imem_req_o, 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 32'hBAD0_0040, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("g_late_valid", bus.instr_valid_o, 0);
    chk("g_addr", bus.imem_addr_o, 32'h0);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 32'h8888_0000, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("g_instr", bus.instr_o, 32'h8888_0000);
    chk("g_pc", bus.instr_pc_o, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
